write_back_pipe: RTL and testbench
==================================

// Module: write_back_pipe
// PURPOSE
//   Registered, handshaked successor to the combinational write-back mux. Sits between the MEM stage and the
//   register file: selects the write-back source, waits for a load response of variable latency, extracts and
//   extends the loaded byte/half/word, and issues a one-cycle register-file write with valid qualification.
// PARAMETERS
//   XLEN        32   datapath width; legal values 32 or 64
//   REG_ADDR_W  5    register index width
//   OFF_W       $clog2(XLEN/8)  byte-offset width (derived; do not override)
// PORTS
//   clk          in   1           clock, rising edge
//   rst_n        in   1           asynchronous, active-low reset
//   flush        in   1           kill the in-flight or pending instruction
//   in_valid     in   1           MEM stage presents an instruction
//   in_ready     out  1           block can accept this cycle
//   wb_sel       in   2           0 ALU_OUT, 1 IMM_DAT, 2 MEM_DAT, 3 PC_NEXT
//   alu_result   in   XLEN        ALU result
//   immediate    in   XLEN        immediate (LUI path)
//   pc_next      in   XLEN        PC+4 (JAL/JALR link)
//   load_funct3  in   3           load type (RISC-V funct3)
//   load_off     in   OFF_W       byte offset of the load address
//   rd_in        in   REG_ADDR_W  destination register
//   reg_we_in    in   1           instruction writes rd
//   mem_rvalid   in   1           load data valid
//   mem_rdata    in   XLEN        raw aligned memory word
//   wb_valid     out  1           one-cycle pulse: write_data/rd_out/reg_we_out are valid
//   write_data   out  XLEN        data to register file
//   rd_out       out  REG_ADDR_W  destination register
//   reg_we_out   out  1           register-file write enable
//   retire_count out  64          retired instructions (only with WB_RETIRE_CNT_EN)
// BEHAVIOUR
//   - Reset: state IDLE; wb_valid, reg_we_out, write_data, rd_out, retire_count all 0; in_ready 1 after reset.
//   - FSM states IDLE, WAIT_MEM. in_ready = (state==IDLE).
//   - Accept = in_valid & in_ready & ~flush.
//   - IDLE, accept, wb_sel!=MEM_DAT: outputs registered next edge; wb_valid=1 one cycle. Latency 1.
//   - IDLE, accept, wb_sel==MEM_DAT, mem_rvalid=1 same cycle: extracted data registered next edge; latency 1.
//   - IDLE, accept, wb_sel==MEM_DAT, mem_rvalid=0: latch rd, reg_we, funct3, offset; -> WAIT_MEM; in_ready=0.
//   - WAIT_MEM, mem_rvalid=1: extract from mem_rdata, register outputs, wb_valid=1 next edge; -> IDLE.
//     Next instruction accepted no earlier than the cycle after mem_rvalid.
//   - mem_rvalid while IDLE with no MEM_DAT accept: ignored.
//   - reg_we_out = latched reg_we & (rd!=0) & wb_valid; x0 never written. wb_valid still pulses for rd=0.
//   - write_data, rd_out hold their last value when wb_valid=0; reg_we_out is 0 whenever wb_valid=0.
//   - Load extraction at byte lane load_off: 000 LB sign-ext byte; 001 LH sign-ext half; 010 LW (sign-ext to
//     XLEN when 64); 100 LBU; 101 LHU zero-ext; 110 LWU zero-ext (XLEN=64); 011 LD (XLEN=64).
//     Unsupported funct3 returns mem_rdata unmodified. For halves/words low offset bits are ignored (aligned).
//   - flush: drops an accept in the same cycle; in WAIT_MEM returns to IDLE with no write, late mem_rvalid
//     dropped. flush and mem_rvalid in the same cycle: flush wins, no wb_valid.
//   - Reset asserted mid-WAIT_MEM: immediate return to IDLE, all outputs cleared, pending load discarded.
// CONFIGURATION
//   WB_RETIRE_CNT_EN defined: retire_count increments by 1 on every wb_valid pulse, wraps at 2^64-1 -> 0,
//     reset to 0, unaffected by flush of unretired instructions.
//   Not defined: retire_count tied to 0; no counter flops synthesised.
// TESTING
//   1. alu_result=1, wb_sel=0, rd_in=5, reg_we_in=1, in_valid 1 cycle -> next cycle wb_valid=1, write_data=1,
//      rd_out=5, reg_we_out=1; following cycle wb_valid=0, reg_we_out=0.
//   2. immediate=2, wb_sel=1, rd_in=0, reg_we_in=1 -> wb_valid=1, write_data=2, reg_we_out=0 (x0).
//   3. wb_sel=2, funct3=000, load_off=3, mem_rvalid low 3 cycles then mem_rdata=0x80FF_FF12 -> in_ready=0
//      while waiting; write_data=0xFFFF_FF80 one cycle after mem_rvalid; LBU same -> 0x0000_0080.
//   4. wb_sel=2, funct3=001, load_off=2, mem_rvalid same cycle, mem_rdata=0x7FFF_0000 -> latency 1,
//      write_data=0x0000_7FFF.
//   5. Load pending in WAIT_MEM, flush=1 with mem_rvalid=1 -> no wb_valid, in_ready=1 next cycle; a later
//      pc_next=4, wb_sel=3 instruction retires with write_data=4.
//   6. rst_n low during WAIT_MEM -> outputs 0, in_ready=1 after release; with WB_RETIRE_CNT_EN, 4 retirements
//      -> retire_count=4, reset -> 0.

Source files
------------

// File: rtl/write_back_pipe.sv
// -----------------------------------------------------------------------------
// write_back_pipe
//   Registered, handshaked write-back stage between MEM and the register file.
//   It selects the write-back source (ALU / immediate / load data / PC+4). For
//   loads it can wait a variable number of cycles for the memory response. It
//   then extracts and extends the addressed byte, half, word or dword, and
//   issues a one-cycle register-file write qualified by wb_valid.
//
//   Optional feature macro: WB_RETIRE_CNT_EN
//     When defined, retire_count is a 64-bit counter of wb_valid pulses.
//     When undefined, retire_count is tied to 0 and no counter flops exist.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   flush            kills the instruction being accepted or the pending load
//   in_valid/ready   MEM-stage handshake; ready only while IDLE
//   wb_sel           0 ALU_OUT, 1 IMM_DAT, 2 MEM_DAT, 3 PC_NEXT
//   alu_result, immediate, pc_next   candidate write-back sources
//   load_funct3, load_off            load type and byte offset
//   rd_in, reg_we_in                 destination register and write enable
//   mem_rvalid, mem_rdata            load response (raw aligned word)
//   wb_valid         one-cycle pulse qualifying write_data/rd_out/reg_we_out
//   write_data, rd_out               hold their last value between pulses
//   reg_we_out       register-file write enable; never set for x0
//   retire_count     retired-instruction count (feature-dependent)
// -----------------------------------------------------------------------------

// Load data extraction: shift the addressed lane down to bit 0, then extend.
// Low offset bits below the access size are ignored, so half/word/dword
// accesses always read an aligned lane.
module wb_load_extract #(
   parameter int XLEN  = 32,
   parameter int OFF_W = $clog2(XLEN/8)
) (
   input  logic [2:0]       funct3,
   input  logic [OFF_W-1:0] off,
   input  logic [XLEN-1:0]  rdata,
   output logic [XLEN-1:0]  data
);
   logic [OFF_W-1:0]   aoff;
   logic [XLEN-1:0]    sh;
   logic signed [7:0]  sb;
   logic signed [15:0] shw;
   logic signed [31:0] sw;

   always_comb begin
      case (funct3[1:0])
         2'b00:   aoff = off;
         2'b01:   aoff = off & ~OFF_W'(1);
         2'b10:   aoff = off & ~OFF_W'(3);
         default: aoff = '0;
      endcase
   end

   assign sh  = rdata >> {aoff, 3'b000};
   assign sb  = sh[7:0];
   assign shw = sh[15:0];
   assign sw  = sh[31:0];

   always_comb begin
      data = rdata;
      case (funct3)
         3'b000: data = XLEN'(sb);
         3'b001: data = XLEN'(shw);
         3'b010: data = XLEN'(sw);
         3'b100: data = XLEN'(sh[7:0]);
         3'b101: data = XLEN'(sh[15:0]);
         // LWU/LD only exist on a 64-bit datapath; otherwise the raw word.
         3'b110: data = (XLEN == 64) ? XLEN'(sh[31:0]) : rdata;
         3'b011: data = (XLEN == 64) ? sh : rdata;
         default: data = rdata;
      endcase
   end
endmodule

module write_back_pipe #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int OFF_W      = $clog2(XLEN/8)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            wb_sel,
   input  logic [XLEN-1:0]       alu_result,
   input  logic [XLEN-1:0]       immediate,
   input  logic [XLEN-1:0]       pc_next,
   input  logic [2:0]            load_funct3,
   input  logic [OFF_W-1:0]      load_off,
   input  logic [REG_ADDR_W-1:0] rd_in,
   input  logic                  reg_we_in,
   input  logic                  mem_rvalid,
   input  logic [XLEN-1:0]       mem_rdata,
   output logic                  wb_valid,
   output logic [XLEN-1:0]       write_data,
   output logic [REG_ADDR_W-1:0] rd_out,
   output logic                  reg_we_out,
   output logic [63:0]           retire_count
);
   localparam logic [1:0] SEL_ALU = 2'd0;
   localparam logic [1:0] SEL_IMM = 2'd1;
   localparam logic [1:0] SEL_MEM = 2'd2;

   typedef enum logic {IDLE, WAIT_MEM} state_t;

   // Context of a load parked while waiting for its memory response.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic                  we;
      logic [2:0]            f3;
      logic [OFF_W-1:0]      off;
   } pend_t;

   state_t state, state_nxt;
   pend_t  pend;

   logic                  accept;
   logic                  park;
   logic                  fire;
   logic [2:0]            ext_f3;
   logic [OFF_W-1:0]      ext_off;
   logic [XLEN-1:0]       ext_data;
   logic [XLEN-1:0]       fire_data;
   logic [REG_ADDR_W-1:0] fire_rd;
   logic                  fire_we;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid & in_ready & ~flush;

   // Extraction controls come from the live inputs on a same-cycle hit and
   // from the parked context once waiting.
   assign ext_f3  = (state == WAIT_MEM) ? pend.f3  : load_funct3;
   assign ext_off = (state == WAIT_MEM) ? pend.off : load_off;

   wb_load_extract #(.XLEN(XLEN), .OFF_W(OFF_W)) u_ext (
      .funct3 (ext_f3),
      .off    (ext_off),
      .rdata  (mem_rdata),
      .data   (ext_data)
   );

   always_comb begin
      state_nxt = state;
      park      = 1'b0;
      fire      = 1'b0;
      fire_data = ext_data;
      fire_rd   = rd_in;
      fire_we   = reg_we_in;
      case (state)
         IDLE: begin
            case (wb_sel)
               SEL_ALU: fire_data = alu_result;
               SEL_IMM: fire_data = immediate;
               SEL_MEM: fire_data = ext_data;
               default: fire_data = pc_next;
            endcase
            if (accept) begin
               if (wb_sel == SEL_MEM && !mem_rvalid) begin
                  park      = 1'b1;
                  state_nxt = WAIT_MEM;
               end else begin
                  fire = 1'b1;
               end
            end
         end
         WAIT_MEM: begin
            fire_rd = pend.rd;
            fire_we = pend.we;
            // flush beats a coincident response: drop it without a write.
            if (flush) begin
               state_nxt = IDLE;
            end else if (mem_rvalid) begin
               fire      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pend  <= '0;
      end else begin
         state <= state_nxt;
         if (park) begin
            pend.rd  <= rd_in;
            pend.we  <= reg_we_in;
            pend.f3  <= load_funct3;
            pend.off <= load_off;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid   <= 1'b0;
         write_data <= '0;
         rd_out     <= '0;
         reg_we_out <= 1'b0;
      end else begin
         wb_valid   <= fire;
         // x0 is architecturally zero: pulse wb_valid but never write it.
         reg_we_out <= fire & fire_we & (fire_rd != '0);
         if (fire) begin
            write_data <= fire_data;
            rd_out     <= fire_rd;
         end
      end
   end

`ifdef WB_RETIRE_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) retire_count <= '0;
      else if (wb_valid) retire_count <= retire_count + 64'd1;
   end
`else
   assign retire_count = '0;
`endif

endmodule

// File: tb/tb_write_back_pipe.sv
module tb_write_back_pipe;
   localparam int XLEN = 32;
   localparam int RW   = 5;
   localparam int OW   = 2;
`ifdef WB_RETIRE_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      wb_sel;
   logic [XLEN-1:0] alu_result, immediate, pc_next;
   logic [2:0]      load_funct3;
   logic [OW-1:0]   load_off;
   logic [RW-1:0]   rd_in;
   logic            reg_we_in;
   logic            mem_rvalid;
   logic [XLEN-1:0] mem_rdata;
   logic            wb_valid;
   logic [XLEN-1:0] write_data;
   logic [RW-1:0]   rd_out;
   logic            reg_we_out;
   logic [63:0]     retire_count;

   int          checks   = 0;
   int          failures = 0;
   logic [63:0] exp_ret  = '0;

   write_back_pipe #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .wb_sel(wb_sel), .alu_result(alu_result), .immediate(immediate), .pc_next(pc_next),
      .load_funct3(load_funct3), .load_off(load_off), .rd_in(rd_in), .reg_we_in(reg_we_in),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
      .write_data(write_data), .rd_out(rd_out), .reg_we_out(reg_we_out),
      .retire_count(retire_count)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; wb_sel = 2'd0;
      alu_result = '0; immediate = '0; pc_next = '0; load_funct3 = '0; load_off = '0;
      rd_in = '0; reg_we_in = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      tick(); tick();
      checks += 6;
      if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
      if (write_data !== '0) begin failures++; $display("FAIL reset_write_data got %h exp 0", write_data); end
      if (rd_out !== '0) begin failures++; $display("FAIL reset_rd_out got %0d exp 0", rd_out); end
      if (reg_we_out !== 1'b0) begin failures++; $display("FAIL reset_reg_we got %b exp 0", reg_we_out); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      if (retire_count !== 64'd0) begin failures++; $display("FAIL reset_retire got %0d exp 0", retire_count); end
      rst_n = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_alu;
      in_valid = 1'b1; wb_sel = 2'd0; alu_result = 32'd1; rd_in = 5'd5; reg_we_in = 1'b1;
      tick();
      in_valid = 1'b0; exp_ret++;
      checks += 4;
      if (wb_valid !== 1'b1) begin failures++; $display("FAIL alu_wb_valid got %b exp 1", wb_valid); end
      if (write_data !== 32'd1) begin failures++; $display("FAIL alu_data got %h exp 1", write_data); end
      if (rd_out !== 5'd5) begin failures++; $display("FAIL alu_rd got %0d exp 5", rd_out); end
      if (reg_we_out !== 1'b1) begin failures++; $display("FAIL alu_we got %b exp 1", reg_we_out); end
      tick();
      checks += 3;
      if (wb_valid !== 1'b0) begin failures++; $display("FAIL alu_pulse_end got %b exp 0", wb_valid); end
      if (reg_we_out !== 1'b0) begin failures++; $display("FAIL alu_we_end got %b exp 0", reg_we_out); end
      if (write_data !== 32'd1) begin failures++; $display("FAIL alu_data_hold got %h exp 1", write_data); end
   endtask

   task automatic test_imm_x0;
      in_valid = 1'b1; wb_sel = 2'd1; immediate = 32'd2; rd_in = 5'd0; reg_we_in = 1'b1;
      tick();
      in_valid = 1'b0; exp_ret++;
      checks += 3;
      if (wb_valid !== 1'b1) begin failures++; $display("FAIL imm_wb_valid got %b exp 1", wb_valid); end
      if (write_data !== 32'd2) begin failures++; $display("FAIL imm_data got %h exp 2", write_data); end
      if (reg_we_out !== 1'b0) begin failures++; $display("FAIL imm_x0_we got %b exp 0", reg_we_out); end
      tick();
   endtask

   task automatic test_load_wait(input logic [2:0] f3, input logic [31:0] exp);
      in_valid = 1'b1; wb_sel = 2'd2; load_funct3 = f3; load_off = 2'd3; rd_in = 5'd9;
      reg_we_in = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      tick();
      // Scramble the live inputs: the parked context must be used.
      in_valid = 1'b0; load_funct3 = 3'b010; load_off = 2'd0; rd_in = 5'd1;
      for (int i = 0; i < 2; i++) begin
         checks += 2;
         if (in_ready !== 1'b0) begin failures++; $display("FAIL ldw_in_ready f3=%0d got %b exp 0", f3, in_ready); end
         if (wb_valid !== 1'b0) begin failures++; $display("FAIL ldw_early f3=%0d got %b exp 0", f3, wb_valid); end
         tick();
      end
      mem_rvalid = 1'b1; mem_rdata = 32'h80FF_FF12;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL ldw_ready_at_rvalid got %b exp 0", in_ready); end
      tick();
      mem_rvalid = 1'b0; exp_ret++;
      checks += 4;
      if (wb_valid !== 1'b1) begin failures++; $display("FAIL ldw_wb_valid f3=%0d got %b exp 1", f3, wb_valid); end
      if (write_data !== exp) begin failures++; $display("FAIL ldw_data f3=%0d got %h exp %h", f3, write_data, exp); end
      if (rd_out !== 5'd9) begin failures++; $display("FAIL ldw_rd got %0d exp 9", rd_out); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL ldw_ready_after got %b exp 1", in_ready); end
      tick();
   endtask

   task automatic test_load_same(input logic [2:0] f3, input logic [1:0] off,
                                 input logic [31:0] rdata, input logic [31:0] exp);
      in_valid = 1'b1; wb_sel = 2'd2; load_funct3 = f3; load_off = off; rd_in = 5'd3;
      reg_we_in = 1'b1; mem_rvalid = 1'b1; mem_rdata = rdata;
      tick();
      in_valid = 1'b0; mem_rvalid = 1'b0; exp_ret++;
      checks += 2;
      if (wb_valid !== 1'b1) begin failures++; $display("FAIL lds_wb_valid f3=%0d off=%0d got %b exp 1", f3, off, wb_valid); end
      if (write_data !== exp) begin failures++; $display("FAIL lds_data f3=%0d off=%0d got %h exp %h", f3, off, write_data, exp); end
   endtask

   task automatic test_flush;
      in_valid = 1'b1; wb_sel = 2'd2; load_funct3 = 3'b010; load_off = 2'd0; rd_in = 5'd4;
      reg_we_in = 1'b1; mem_rvalid = 1'b0;
      tick();
      in_valid = 1'b0; flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      tick();
      flush = 1'b0; mem_rvalid = 1'b0;
      checks += 2;
      if (wb_valid !== 1'b0) begin failures++; $display("FAIL flush_wb_valid got %b exp 0", wb_valid); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got %b exp 1", in_ready); end
      mem_rvalid = 1'b1;  // late response, no load pending
      tick();
      mem_rvalid = 1'b0;
      checks++;
      if (wb_valid !== 1'b0) begin failures++; $display("FAIL late_rvalid got %b exp 0", wb_valid); end
      in_valid = 1'b1; wb_sel = 2'd0; alu_result = 32'h55; flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (wb_valid !== 1'b0) begin failures++; $display("FAIL flush_accept got %b exp 0", wb_valid); end
      wb_sel = 2'd3; pc_next = 32'd4; rd_in = 5'd7;
      tick();
      in_valid = 1'b0; exp_ret++;
      checks += 3;
      if (wb_valid !== 1'b1) begin failures++; $display("FAIL pc_wb_valid got %b exp 1", wb_valid); end
      if (write_data !== 32'd4) begin failures++; $display("FAIL pc_data got %h exp 4", write_data); end
      if (rd_out !== 5'd7) begin failures++; $display("FAIL pc_rd got %0d exp 7", rd_out); end
      tick();
   endtask

   task automatic test_back_to_back;
      in_valid = 1'b1; wb_sel = 2'd0; alu_result = 32'h11; rd_in = 5'd1; reg_we_in = 1'b1;
      tick();
      alu_result = 32'h22; rd_in = 5'd2;
      checks += 2;
      if (wb_valid !== 1'b1) begin failures++; $display("FAIL b2b_first_valid got %b exp 1", wb_valid); end
      if (write_data !== 32'h11) begin failures++; $display("FAIL b2b_first_data got %h exp 11", write_data); end
      tick();
      in_valid = 1'b0; exp_ret += 2;
      checks += 3;
      if (wb_valid !== 1'b1) begin failures++; $display("FAIL b2b_second_valid got %b exp 1", wb_valid); end
      if (write_data !== 32'h22) begin failures++; $display("FAIL b2b_second_data got %h exp 22", write_data); end
      if (rd_out !== 5'd2) begin failures++; $display("FAIL b2b_second_rd got %0d exp 2", rd_out); end
      tick();
      checks += 2;
      if (wb_valid !== 1'b0) begin failures++; $display("FAIL b2b_end got %b exp 0", wb_valid); end
      if (retire_count !== (CNT_EN ? exp_ret : 64'd0)) begin
         failures++; $display("FAIL retire_running got %0d exp %0d", retire_count, CNT_EN ? exp_ret : 64'd0);
      end
   endtask

   task automatic test_reset_mid;
      in_valid = 1'b1; wb_sel = 2'd2; load_funct3 = 3'b010; rd_in = 5'd6; mem_rvalid = 1'b0;
      tick();
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_pending got %b exp 0", in_ready); end
      rst_n = 1'b0;
      #1;
      exp_ret = '0;
      checks += 5;
      if (write_data !== '0) begin failures++; $display("FAIL rst_mid_data got %h exp 0", write_data); end
      if (rd_out !== '0) begin failures++; $display("FAIL rst_mid_rd got %0d exp 0", rd_out); end
      if (wb_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got %b exp 0", wb_valid); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got %b exp 1", in_ready); end
      if (retire_count !== 64'd0) begin failures++; $display("FAIL rst_mid_retire got %0d exp 0", retire_count); end
      tick();
      rst_n = 1'b1;
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      tick();
      mem_rvalid = 1'b0;
      checks++;
      if (wb_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_discard got %b exp 0", wb_valid); end
      in_valid = 1'b1; wb_sel = 2'd0; alu_result = 32'h9; rd_in = 5'd8;
      repeat (4) tick();
      in_valid = 1'b0; exp_ret = 64'd4;
      tick();
      checks++;
      if (retire_count !== (CNT_EN ? exp_ret : 64'd0)) begin
         failures++; $display("FAIL retire_four got %0d exp %0d", retire_count, CNT_EN ? exp_ret : 64'd0);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (retire_count !== 64'd0) begin failures++; $display("FAIL retire_clear got %0d exp 0", retire_count); end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_imm_x0();
      test_load_wait(3'b000, 32'hFFFF_FF80);
      test_load_wait(3'b100, 32'h0000_0080);
      test_load_same(3'b001, 2'd2, 32'h7FFF_0000, 32'h0000_7FFF);
      test_load_same(3'b001, 2'd3, 32'h7FFF_0000, 32'h0000_7FFF);
      test_load_same(3'b001, 2'd0, 32'h0000_8001, 32'hFFFF_8001);
      test_load_same(3'b101, 2'd0, 32'h0000_8001, 32'h0000_8001);
      test_load_same(3'b100, 2'd1, 32'h0000_A500, 32'h0000_00A5);
      test_load_same(3'b000, 2'd2, 32'h0042_0000, 32'h0000_0042);
      test_load_same(3'b010, 2'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      test_load_same(3'b011, 2'd1, 32'h1234_5678, 32'h1234_5678);
      tick();
      test_flush();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
